// File: rtl/alu_pkg.sv
// alu_pkg: opcode, FSM state and width constants shared by seq_alu, the operand selector and their benches.
package alu_pkg;
    localparam int DEF_DW = 8;
    typedef enum logic [2:0] {
        OP_ADD = 3'd0, OP_SUB = 3'd1, OP_MUL = 3'd2, OP_DIV = 3'd3,
        OP_MOD = 3'd4, OP_EQ  = 3'd5, OP_GT  = 3'd6, OP_LT  = 3'd7
    } op_e;
    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_e;
endpackage

// File: rtl/seq_alu_if.sv
// seq_alu_if: operand request and result response handshakes of seq_alu.
interface seq_alu_if
    import alu_pkg::*;
#(parameter int DW = DEF_DW);
    logic            in_valid, in_ready, out_valid, out_ready, carry, zero, err;
    logic [DW-1:0]   a, b;
    logic [2:0]      opcode;
    logic [2*DW-1:0] result;
    modport master (output in_valid, a, b, opcode, out_ready,
                    input  in_ready, out_valid, result, carry, zero, err);
    modport slave  (input  in_valid, a, b, opcode, out_ready,
                    output in_ready, out_valid, result, carry, zero, err);
endinterface

// File: rtl/seq_alu_iter.sv
// seq_alu_iter: shift-add multiplier / restoring divider sharing one hi:lo register pair, one step per enabled cycle.
module seq_alu_iter
    import alu_pkg::*;
#(parameter int DW = DEF_DW, parameter int ITER = DW) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic            en_i,
    input  logic            mul_i,
    input  logic [DW-1:0]   a_i,
    input  logic [DW-1:0]   b_i,
    output logic            done_o,
    output logic [2*DW-1:0] res_o
);
    localparam int CW = $clog2(ITER);
    logic [DW-1:0] hi_q, hi_d, lo_q, lo_d, m_q;
    logic [CW-1:0] cnt_q;
    logic          mul_q;
    logic [DW:0]   sum, trial;
    // hi holds the partial product or the running remainder; lo the multiplier or the dividend/quotient
    always_comb begin
        sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
        trial = {hi_q, lo_q[DW-1]} - {1'b0, m_q};
        hi_d  = mul_q ? sum[DW:1] : trial[DW] ? {hi_q[DW-2:0], lo_q[DW-1]} : trial[DW-1:0];
        lo_d  = mul_q ? {sum[0], lo_q[DW-1:1]} : {lo_q[DW-2:0], ~trial[DW]};
    end
    assign done_o = en_i && cnt_q == CW'(ITER - 1);
    assign res_o  = {hi_d, lo_d};
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            hi_q  <= '0;
            lo_q  <= '0;
            m_q   <= '0;
            cnt_q <= '0;
            mul_q <= 1'b0;
        end else if (start_i) begin
            hi_q  <= '0;
            lo_q  <= a_i;
            m_q   <= b_i;
            cnt_q <= '0;
            mul_q <= mul_i;
        end else if (en_i) begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            cnt_q <= cnt_q + 1'b1;
        end
endmodule

// File: rtl/seq_alu.sv
// seq_alu: multi-cycle 8-bit ALU with valid/ready in and out; MUL/DIV/MOD iterate in seq_alu_iter.
// SEQ_ALU_SIGNED_CMP_EN makes GT/LT two's complement compares.
module seq_alu
    import alu_pkg::*;
#(parameter int DW = DEF_DW, parameter int ITER = DW) (
    input logic      clk,
    input logic      rst,
    seq_alu_if.slave bus
);
    state_e          state_q, state_d;
    op_e             op_q;
    logic [DW-1:0]   a_q, b_q;
    logic [2*DW-1:0] result_q, result_d, iter_res, fin;
    logic            carry_q, carry_d, zero_q, zero_d, err_q, err_d;
    logic            accept, iter_op, div0, iter_en, iter_done, gt, lt;
    logic [DW:0]     add_s, sub_s;
    assign accept  = state_q == S_IDLE && bus.in_valid;
    assign iter_op = op_q inside {OP_MUL, OP_DIV, OP_MOD};
    assign div0    = op_q inside {OP_DIV, OP_MOD} && b_q == '0;
    assign iter_en = state_q == S_EXEC && iter_op && !div0;
    assign add_s   = {1'b0, a_q} + {1'b0, b_q};
    assign sub_s   = {1'b0, a_q} - {1'b0, b_q};
`ifdef SEQ_ALU_SIGNED_CMP_EN
    assign gt = $signed(a_q) > $signed(b_q);
    assign lt = $signed(a_q) < $signed(b_q);
`else
    assign gt = a_q > b_q;
    assign lt = a_q < b_q;
`endif
    seq_alu_iter #(.DW(DW), .ITER(ITER)) u_iter (
        .clk(clk), .rst(rst), .start_i(accept), .en_i(iter_en),
        .mul_i(op_e'(bus.opcode) == OP_MUL), .a_i(bus.a), .b_i(bus.b),
        .done_o(iter_done), .res_o(iter_res)
    );
    // divide by zero: quotient all-ones, remainder = a
    assign fin = op_q == OP_ADD ? {{(DW-1){1'b0}}, add_s} :
                 op_q == OP_SUB ? {{DW{1'b0}}, sub_s[DW-1:0]} :
                 op_q == OP_EQ  ? (2*DW)'(a_q == b_q) :
                 op_q == OP_GT  ? (2*DW)'(gt) :
                 op_q == OP_LT  ? (2*DW)'(lt) :
                 div0           ? (op_q == OP_DIV ? {a_q, {DW{1'b1}}} : {{DW{1'b0}}, a_q}) :
                 op_q == OP_MOD ? {{DW{1'b0}}, iter_res[2*DW-1:DW]} : iter_res;
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        carry_d  = carry_q;
        zero_d   = zero_q;
        err_d    = err_q;
        case (state_q)
            S_IDLE: state_d = bus.in_valid ? S_EXEC : S_IDLE;
            S_EXEC: if (!iter_op || div0 || iter_done) begin
                state_d  = S_DONE;
                result_d = fin;
                carry_d  = op_q == OP_ADD ? add_s[DW] : (op_q == OP_SUB) & sub_s[DW];
                zero_d   = fin == '0;
                err_d    = div0;
            end
            S_DONE: state_d = bus.out_ready ? S_IDLE : S_DONE;
            default: state_d = S_IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= OP_ADD;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
            err_q    <= err_d;
            if (accept) begin
                a_q  <= bus.a;
                b_q  <= bus.b;
                op_q <= op_e'(bus.opcode);
            end
        end
    assign bus.in_ready  = state_q == S_IDLE;
    assign bus.out_valid = state_q == S_DONE;
    assign bus.result    = result_q;
    assign bus.carry     = carry_q;
    assign bus.zero      = zero_q;
    assign bus.err       = err_q;
endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Multi-cycle 8-bit ALU sitting directly downstream of the manual/CPU operand selector.
- Consumes the selected operand pair (a, b) and 3-bit opcode through a valid/ready handshake.
- Produces a 16-bit result plus status flags through a second valid/ready handshake.
- ADD/SUB/compare ops complete in one execute cycle; MUL, DIV and MOD run iteratively (shift-add multiply, restoring divide).

Parameters:
- DW, 8, operand width in bits; result width is 2*DW.
- ITER, 8, iteration count for MUL/DIV/MOD; must equal DW.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand/opcode valid
- in_ready  output  1  block can accept operands
- a  input  DW  operand A (from select_a)
- b  input  DW  operand B (from select_b)
- opcode  input  3  operation (from select_opcode)
- out_valid  output  1  result valid, held until taken
- out_ready  input  1  downstream accepts result
- result  output  2*DW  operation result
- carry  output  1  ADD carry-out / SUB borrow
- zero  output  1  result == 0
- err  output  1  DIV/MOD by zero

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, result=0, carry=0, zero=0, err=0, iteration counter=0.
- Opcodes:
  - 000 ADD: result = {0, a+b}; carry = bit DW.
  - 001 SUB: result = {0, (a-b) mod 2^DW}; carry = borrow (a<b).
  - 010 MUL: result = a*b, full 2*DW bits.
  - 011 DIV: result = {remainder, quotient}.
  - 100 MOD: result = {0, remainder}.
  - 101 EQ: result = (a==b).
  - 110 GT: result = (a>b).
  - 111 LT: result = (a<b).
  - Compares are unsigned by default.
- FSM with three states:
  - IDLE: in_ready=1. On in_valid, latch a, b and opcode, go to EXEC, counter=0.
  - EXEC: in_ready=0.
    - Single-cycle ops: compute, go to DONE after 1 cycle.
    - MUL/DIV/MOD: one iteration per cycle. Go to DONE when counter==ITER-1.
    - DIV/MOD with b==0: go to DONE after 1 cycle with quotient = all-ones, remainder = a, err=1.
  - DONE: out_valid=1; result and flags stable. On out_ready, go to IDLE.
- Latency, with acceptance edge = E0:
  - Single-cycle ops: out_valid high after E1.
  - MUL/DIV/MOD: out_valid high after E8.
  - Throughput is one operation per (latency + 2) cycles minimum; in_ready returns one cycle after the out_ready handshake.
- Input stability: a, b and opcode are captured only at acceptance. Upstream changes while busy (including a mode switch) have no effect on the operation in flight.
- Output registers: carry, zero and err update only on entry to DONE; err=0 for all non-divide ops.
- Reset mid-operation (EXEC or DONE): immediate return to the reset values; the result in flight is discarded.
- Simultaneous events:
  - in_valid asserted while not in IDLE is ignored; there is no queue.
  - out_ready while out_valid=0 is ignored.

Optional Feature:
- Macro: SEQ_ALU_SIGNED_CMP_EN.
- Defined: GT/LT treat a and b as two's complement; EQ, arithmetic and divide are unchanged.
- Undefined: all compares are unsigned.

Decomposition:
- Shared package alu_pkg holds:
  - opcode constants OP_ADD through OP_LT;
  - FSM state encodings S_IDLE, S_EXEC, S_DONE;
  - default DW.
- These constants are shared with the selector and its bench.
- Sub-module seq_alu_iter holds the iterative datapath (shift-add multiplier and restoring divider registers plus counter), driven by start/op inputs and returning a done pulse.
- The FSM and single-cycle ops stay in seq_alu.

Test Plan:
- Accept a=10, b=5, op=000, out_ready=1 -> out_valid after E1, result=15, carry=0, zero=0.
- a=5, b=7, op=001 -> result=0x00FE, carry=1.
- a=20, b=3, op=010 -> out_valid exactly after E8, result=60; then a=255, b=255, op=010 -> result=65025.
- a=40, b=8, op=011 -> result=0x0005 (rem 0, quot 5), zero=0; then a=7, b=0, op=011 -> after E1, result=0x07FF, err=1.
- a=25, b=25, op=101 -> result=1; a=60, b=30, op=110 -> result=1. With SEQ_ALU_SIGNED_CMP_EN, a=0x80, b=0x01, op=110 -> result=0.
- Hold out_ready=0 for 5 cycles after DONE -> result stable, in_ready=0, new in_valid ignored. Separately, assert rst at the 4th MUL iteration -> all outputs at reset values and in_ready=1 immediately.
